// File: rtl/acc_op_sequencer.sv
// Accumulator-group (0xF_) instruction sequencer: reads the accumulator over the shared bus,
// computes result and carry, writes back through load/increment controls. Owns the carry flag.
module acc_op_sequencer #(
    parameter int   W          = 4,
    parameter logic CARRY_INIT = 1'b0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [3:0]   opcode,
    output logic         ready,
    output logic         done,
    output logic         illegal,
    output logic         acc_sel,
    input  logic [W-1:0] acc_rdata,
    output logic         acc_we,
    output logic         acc_inc,
    output logic [W-1:0] acc_wdata,
    output logic         carry
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WRITE,
        S_DONE
    } state_t;

    typedef enum logic [3:0] {
        OP_CLB = 4'h0, OP_CLC = 4'h1, OP_IAC = 4'h2, OP_CMC = 4'h3,
        OP_CMA = 4'h4, OP_RAL = 4'h5, OP_RAR = 4'h6, OP_TCC = 4'h7,
        OP_DAC = 4'h8, OP_TCS = 4'h9, OP_STC = 4'hA, OP_DAA = 4'hB,
        OP_KBP = 4'hC
    } op_t;

    state_t       state;
    logic [3:0]   op_q;
    logic [W-1:0] tmp;
    logic         we_q;
    logic         inc_q;
    logic         nc_q;
    logic         ill_q;

    logic [W-1:0] res;
    logic         nc;
    logic         do_we;
    logic         do_inc;
    logic         is_ill;
    logic [W:0]   daa_sum;

    // Result and new carry for the latched opcode, evaluated while in EXEC.
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        res     = '0;
        nc      = carry;
        do_we   = 1'b0;
        do_inc  = 1'b0;
        is_ill  = 1'b0;
        daa_sum = {1'b0, tmp} + (W+1)'(6);
        case (op_q)
            OP_CLB: begin do_we = 1'b1; res = '0; nc = 1'b0; end
            OP_CLC: nc = 1'b0;
            OP_IAC: begin do_inc = 1'b1; nc = (tmp == {W{1'b1}}); end
            OP_CMC: nc = ~carry;
            OP_CMA: begin do_we = 1'b1; res = ~tmp; end
            OP_RAL: begin do_we = 1'b1; res = {tmp[W-2:0], carry}; nc = tmp[W-1]; end
            OP_RAR: begin do_we = 1'b1; res = {carry, tmp[W-1:1]}; nc = tmp[0]; end
            OP_TCC: begin do_we = 1'b1; res = {{(W-1){1'b0}}, carry}; nc = 1'b0; end
            OP_DAC: begin do_we = 1'b1; res = tmp - W'(1); nc = (tmp != '0); end
            OP_TCS: begin do_we = 1'b1; res = carry ? W'(10) : W'(9); nc = 1'b0; end
            OP_STC: nc = 1'b1;
            OP_DAA: begin
                if (tmp > W'(9) || carry) begin
                    do_we = 1'b1;
                    res   = daa_sum[W-1:0];
                    nc    = daa_sum[W] ? 1'b1 : carry;
                end
            end
            OP_KBP: begin
                do_we = 1'b1;
                case (tmp)
                    W'(0):   res = W'(0);
                    W'(1):   res = W'(1);
                    W'(2):   res = W'(2);
                    W'(4):   res = W'(3);
                    W'(8):   res = W'(4);
                    default: res = {W{1'b1}};
                endcase
            end
            default: is_ill = 1'b1;
        endcase
    end

    // Write strobes are registered, but a reset arriving during WRITE must keep the
    // accumulator from loading on that same edge, so the synchronous reset masks them.
    assign acc_we  = we_q  & ~reset;
    assign acc_inc = inc_q & ~reset;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // sees the pre-edge values of its neighbours regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            ready     <= 1'b1;
            done      <= 1'b0;
            illegal   <= 1'b0;
            acc_sel   <= 1'b0;
            we_q      <= 1'b0;
            inc_q     <= 1'b0;
            acc_wdata <= '0;
            carry     <= CARRY_INIT;
            op_q      <= '0;
            tmp       <= '0;
            nc_q      <= 1'b0;
            ill_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q    <= opcode;
                        acc_sel <= 1'b1;
                        ready   <= 1'b0;
                        state   <= S_READ;
                    end
                end
                S_READ: begin
                    tmp     <= acc_rdata;
                    acc_sel <= 1'b0;
                    state   <= S_EXEC;
                end
                S_EXEC: begin
                    we_q      <= do_we;
                    inc_q     <= do_inc;
                    acc_wdata <= do_we ? res : '0;
                    nc_q      <= nc;
                    ill_q     <= is_ill;
                    state     <= S_WRITE;
                end
                S_WRITE: begin
                    carry     <= nc_q;
                    we_q      <= 1'b0;
                    inc_q     <= 1'b0;
                    acc_wdata <= '0;
                    done      <= 1'b1;
                    illegal   <= ill_q;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    done    <= 1'b0;
                    illegal <= 1'b0;
                    ready   <= 1'b1;
                    state   <= S_IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acc_op_sequencer.sv
// Scoreboard bench for acc_op_sequencer: a bus-driving accumulator model, directed ops with
// hand-computed results, and a monitor that checks each retirement against the queue.
module tb_acc_op_sequencer;

    localparam logic CARRY_INIT = 1'b0;
    // Accept at edge N; DONE occupies the cycle between edges N+3 and N+4.
    localparam int DONE_LAT = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic       ready, done, illegal, acc_sel, acc_we, acc_inc, carry;
    logic [3:0] acc_wdata;
    wire  [3:0] acc_rdata;

    logic [3:0] acc;
    logic       load_req = 1'b0;
    logic [3:0] load_val = 4'h0;
    int         cyc = 0;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [3:0] op;
        logic [3:0] acc;
        logic       c;
        logic       ill;
        int         n_we;
        int         n_inc;
        int         acc_cyc;
    } exp_t;

    exp_t sb[$];

    acc_op_sequencer #(.W(4), .CARRY_INIT(CARRY_INIT)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .opcode    (opcode),
        .ready     (ready),
        .done      (done),
        .illegal   (illegal),
        .acc_sel   (acc_sel),
        .acc_rdata (acc_rdata),
        .acc_we    (acc_we),
        .acc_inc   (acc_inc),
        .acc_wdata (acc_wdata),
        .carry     (carry)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Accumulator model: drives the shared bus only while selected.
    assign acc_rdata = acc_sel ? acc : 4'bz;
    always @(posedge clock) begin
        if (load_req)     acc <= load_val;
        else if (acc_we)  acc <= acc_wdata;
        else if (acc_inc) acc <= acc + 4'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: strobe counts per operation, compared when the DUT retires it.
    int  mon_we = 0, mon_inc = 0;
    bit  mon_both = 1'b0;
    always @(negedge clock) begin
        if (reset) begin
            mon_we = 0; mon_inc = 0; mon_both = 1'b0;
        end else begin
            if (acc_we)  mon_we++;
            if (acc_inc) mon_inc++;
            if (acc_we && acc_inc) mon_both = 1'b1;
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check($sformatf("op%0h_acc", e.op), acc, e.acc);
                    check($sformatf("op%0h_carry", e.op), carry, e.c);
                    check($sformatf("op%0h_illegal", e.op), illegal, e.ill);
                    check($sformatf("op%0h_we_cnt", e.op), mon_we, e.n_we);
                    check($sformatf("op%0h_inc_cnt", e.op), mon_inc, e.n_inc);
                    check($sformatf("op%0h_we_inc_both", e.op), mon_both, 0);
                    check($sformatf("op%0h_latency", e.op), cyc - e.acc_cyc, DONE_LAT);
                end
                mon_we = 0; mon_inc = 0; mon_both = 1'b0;
            end else if (illegal) begin
                check("illegal_without_done", 1, 0);
            end
        end
    end

    task automatic push(input logic [3:0] op, input logic [3:0] a, input logic c,
                        input logic ill, input int nwe, input int ninc);
        exp_t e;
        e.op = op; e.acc = a; e.c = c; e.ill = ill;
        e.n_we = nwe; e.n_inc = ninc; e.acc_cyc = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 50 && !ready; i++) @(negedge clock);
        if (!ready) check("ready_timeout", 0, 1);
    endtask

    task automatic issue(input logic [3:0] op, input logic [3:0] a, input logic c,
                         input logic ill, input int nwe, input int ninc);
        @(negedge clock);
        wait_ready();
        start  = 1'b1;
        opcode = op;
        push(op, a, c, ill, nwe, ninc);
        @(negedge clock);
        start  = 1'b0;
        opcode = ~op;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clock);
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
        @(negedge clock);
    endtask

    task automatic load(input logic [3:0] v);
        drain();
        load_req = 1'b1;
        load_val = v;
        @(negedge clock);
        load_req = 1'b0;
    endtask

    initial begin
        int a1, a2;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_illegal", illegal, 0);
        check("rst_acc_sel", acc_sel, 0);
        check("rst_we", acc_we, 0);
        check("rst_inc", acc_inc, 0);
        check("rst_wdata", acc_wdata, 0);
        check("rst_carry", carry, CARRY_INIT);
        reset = 1'b0;

        // RAL: 0111,c0 -> 1110, c=0
        load(4'h7);
        issue(4'h5, 4'hE, 1'b0, 1'b0, 1, 0);
        // IAC on F wraps with carry; DAC on 0 borrows
        load(4'hF);
        issue(4'h2, 4'h0, 1'b1, 1'b0, 0, 1);
        issue(4'h8, 4'hF, 1'b0, 1'b0, 1, 0);
        // DAA: B -> 1 with carry; CLC; 5 with c=0 untouched
        load(4'hB);
        issue(4'hB, 4'h1, 1'b1, 1'b0, 1, 0);
        issue(4'h1, 4'h1, 1'b0, 1'b0, 0, 0);
        load(4'h5);
        issue(4'hB, 4'h5, 1'b0, 1'b0, 0, 0);
        // KBP and TCS
        load(4'h4);
        issue(4'hC, 4'h3, 1'b0, 1'b0, 1, 0);
        load(4'h6);
        issue(4'hC, 4'hF, 1'b0, 1'b0, 1, 0);
        issue(4'hA, 4'hF, 1'b1, 1'b0, 0, 0);
        issue(4'h9, 4'hA, 1'b0, 1'b0, 1, 0);
        // CMA, CMC, RAR, TCC, CLB, DAC non-zero
        issue(4'h4, 4'h5, 1'b0, 1'b0, 1, 0);
        issue(4'h3, 4'h5, 1'b1, 1'b0, 0, 0);
        issue(4'h6, 4'hA, 1'b1, 1'b0, 1, 0);
        issue(4'h7, 4'h1, 1'b0, 1'b0, 1, 0);
        load(4'h3);
        issue(4'h8, 4'h2, 1'b1, 1'b0, 1, 0);

        // start held through busy: CMC accepted, opcode swapped to CMA, CMA taken at next ready
        drain();
        wait_ready();
        start  = 1'b1;
        opcode = 4'h3;
        push(4'h3, 4'h2, 1'b0, 1'b0, 0, 0);
        a1 = cyc + 1;
        @(negedge clock);
        opcode = 4'h4;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (ready) break;
        end
        check("held_start_ready", ready, 1);
        push(4'h4, 4'hD, 1'b0, 1'b0, 1, 0);
        a2 = cyc + 1;
        check("held_start_gap", a2 - a1, 5);
        @(negedge clock);
        start = 1'b0;
        // illegal opcode E leaves acc and carry alone
        issue(4'hE, 4'hD, 1'b0, 1'b1, 0, 0);

        // reset during WRITE of CLB with acc=9, carry=1
        load(4'h9);
        issue(4'hA, 4'h9, 1'b1, 1'b0, 0, 0);
        drain();
        wait_ready();
        start  = 1'b1;
        opcode = 4'h0;
        @(negedge clock);        // READ
        start = 1'b0;
        @(negedge clock);        // EXEC
        @(negedge clock);        // WRITE
        check("abort_we_before_reset", acc_we, 1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("abort_acc", acc, 4'h9);
        check("abort_ready", ready, 1);
        check("abort_carry", carry, CARRY_INIT);
        check("abort_we", acc_we, 0);
        check("abort_done", done, 0);
        @(negedge clock);
        reset = 1'b0;
        issue(4'h2, 4'hA, 1'b0, 1'b0, 0, 1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule
